// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Holds the FSM state encoding, the parity mode codes, the fifo_count
// width helper and the 2-of-3 vote used by the majority-sampling build.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Width of an occupancy counter that must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // 2-of-3 majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receive-side drain interface: FIFO head, valid/ready handshake and
// occupancy. The receiver drives it through the master modport, the
// consumer (command parser) uses the slave modport.
interface uart_rx_param_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) ();
    import uart_rx_pkg::*;

    logic [DATA_BITS-1:0]             data_out;
    logic                             data_valid;
    logic                             data_ready;
    logic [cnt_width(FIFO_DEPTH)-1:0] fifo_count;

    modport master (output data_out, output data_valid, output fifo_count, input data_ready);
    modport slave  (input data_out, input data_valid, input fifo_count, output data_ready);

endinterface

// File: rtl/uart_rx_fifo.sv
// Small circular receive FIFO. A push while full is accepted only when a
// pop happens on the same edge; a pop while empty is ignored. The head is
// forced to zero when the FIFO is empty so stale entries never show.
module uart_rx_fifo import uart_rx_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;

    // Qualify the requests against the current occupancy and expose the head.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        if (empty) begin
            head = {WIDTH{1'b0}};
        end else begin
            head = mem_r[rd_ptr_r];
        end
    end

    // Storage array write; contents need no reset since count gates the head.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input synchroniser, start-bit glitch
// rejection, optional parity, 1 or 2 stop bits, per-frame error pulses and
// a receive FIFO drained over uart_rx_param_if.
// Build option: define UART_RX_MAJORITY_EN to take each bit as the 2-of-3
// majority of the last three synchronised samples at the bit middle.
module uart_rx_param import uart_rx_pkg::*; #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int OVERSAMPLING = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            baud,
    input  logic            reset,
    input  logic            enable,
    input  logic            rx,
    uart_rx_param_if.master rx_if,
    output logic            busy,
    output logic            parity_err,
    output logic            frame_err,
    output logic            overrun
);
    localparam int OSW = $clog2(OVERSAMPLING);
    localparam int BCW = $clog2(DATA_BITS);
    localparam logic [OSW-1:0] OS_LAST    = OSW'(OVERSAMPLING - 1);
    localparam logic [OSW-1:0] OS_HALF    = OSW'(OVERSAMPLING / 2 - 1);
    localparam logic [BCW-1:0] BIT_LAST   = BCW'(DATA_BITS - 1);
    localparam logic           STOP_LAST  = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic           PAR_EXPECT = (PARITY_MODE == PARITY_ODD) ? 1'b1 : 1'b0;

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_START  = ST_START;
    localparam logic [2:0] S_DATA   = ST_DATA;
    localparam logic [2:0] S_PARITY = ST_PARITY;
    localparam logic [2:0] S_STOP   = ST_STOP;

    logic                 sync1_r;
    logic                 rxs_r;
`ifdef UART_RX_MAJORITY_EN
    logic [1:0]           hist_r;
`endif
    logic [2:0]           state_r;
    logic [OSW-1:0]       os_cnt_r;
    logic [BCW-1:0]       bit_cnt_r;
    logic                 stop_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 acc_r;
    logic                 par_bad_r;
    logic                 frm_bad_r;
    logic                 busy_r;
    logic                 parity_err_r;
    logic                 frame_err_r;
    logic                 overrun_r;
    logic                 smp_s;
    logic                 at_mid_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;

    assign busy             = busy_r;
    assign parity_err       = parity_err_r;
    assign frame_err        = frame_err_r;
    assign overrun          = overrun_r;
    assign rx_if.data_valid = ~fifo_empty_s;

    // Two-flop synchroniser (plus vote history) for the asynchronous rx pin.
    always_ff @(posedge baud) begin
        if (reset) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            hist_r  <= 2'b11;
`endif
        end else begin
            sync1_r <= rx;
            rxs_r   <= sync1_r;
`ifdef UART_RX_MAJORITY_EN
            hist_r  <= {hist_r[0], rxs_r};
`endif
        end
    end

    // Bit decision, drain handshake, and FIFO push on a clean final stop sample.
    always_comb begin
`ifdef UART_RX_MAJORITY_EN
        smp_s = maj3(hist_r[1], hist_r[0], rxs_r);
`else
        smp_s = rxs_r;
`endif
        at_mid_s = (os_cnt_r == OS_LAST);
        pop_s    = ~fifo_empty_s & rx_if.data_ready;
        if (enable && (state_r == S_STOP) && at_mid_s && (stop_cnt_r == STOP_LAST)) begin
            push_s = ~par_bad_r & ~frm_bad_r & smp_s;
        end else begin
            push_s = 1'b0;
        end
    end

    // Frame FSM: start qualification, data shift, parity and stop checks.
    always_ff @(posedge baud) begin
        if (reset) begin
            state_r      <= S_IDLE;
            os_cnt_r     <= {OSW{1'b0}};
            bit_cnt_r    <= {BCW{1'b0}};
            stop_cnt_r   <= 1'b0;
            shift_r      <= {DATA_BITS{1'b0}};
            acc_r        <= 1'b0;
            par_bad_r    <= 1'b0;
            frm_bad_r    <= 1'b0;
            busy_r       <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= push_s & fifo_full_s & ~pop_s;
            if (!enable) begin
                state_r  <= S_IDLE;
                os_cnt_r <= {OSW{1'b0}};
                busy_r   <= 1'b0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (!rxs_r) begin
                            state_r    <= S_START;
                            os_cnt_r   <= OSW'(1);
                            busy_r     <= 1'b1;
                            bit_cnt_r  <= {BCW{1'b0}};
                            stop_cnt_r <= 1'b0;
                            acc_r      <= 1'b0;
                            par_bad_r  <= 1'b0;
                            frm_bad_r  <= 1'b0;
                        end
                    end
                    S_START: begin
`ifdef UART_RX_MAJORITY_EN
                        if (os_cnt_r == OS_HALF) begin
                            if (smp_s) begin
                                state_r <= S_IDLE;
                                busy_r  <= 1'b0;
                            end else begin
                                state_r <= S_DATA;
                            end
                            os_cnt_r <= {OSW{1'b0}};
                        end else begin
                            os_cnt_r <= os_cnt_r + OSW'(1);
                        end
`else
                        if (rxs_r) begin
                            state_r  <= S_IDLE;
                            os_cnt_r <= {OSW{1'b0}};
                            busy_r   <= 1'b0;
                        end else if (os_cnt_r == OS_HALF) begin
                            state_r  <= S_DATA;
                            os_cnt_r <= {OSW{1'b0}};
                        end else begin
                            os_cnt_r <= os_cnt_r + OSW'(1);
                        end
`endif
                    end
                    S_DATA: begin
                        if (at_mid_s) begin
                            os_cnt_r <= {OSW{1'b0}};
                            shift_r  <= {smp_s, shift_r[DATA_BITS-1:1]};
                            acc_r    <= acc_r ^ smp_s;
                            if (bit_cnt_r == BIT_LAST) begin
                                bit_cnt_r <= {BCW{1'b0}};
                                state_r   <= (PARITY_MODE == PARITY_NONE) ? S_STOP : S_PARITY;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + BCW'(1);
                            end
                        end else begin
                            os_cnt_r <= os_cnt_r + OSW'(1);
                        end
                    end
                    S_PARITY: begin
                        if (at_mid_s) begin
                            os_cnt_r  <= {OSW{1'b0}};
                            par_bad_r <= ((acc_r ^ smp_s) != PAR_EXPECT);
                            state_r   <= S_STOP;
                        end else begin
                            os_cnt_r <= os_cnt_r + OSW'(1);
                        end
                    end
                    S_STOP: begin
                        if (at_mid_s) begin
                            os_cnt_r <= {OSW{1'b0}};
                            if (!smp_s) begin
                                frame_err_r <= 1'b1;
                                frm_bad_r   <= 1'b1;
                            end
                            // Leave mid-stop-bit so the next start edge is caught promptly.
                            if (stop_cnt_r == STOP_LAST) begin
                                state_r      <= S_IDLE;
                                busy_r       <= 1'b0;
                                parity_err_r <= par_bad_r;
                            end else begin
                                stop_cnt_r <= stop_cnt_r + 1'b1;
                            end
                        end else begin
                            os_cnt_r <= os_cnt_r + OSW'(1);
                        end
                    end
                    default: begin
                        state_r  <= S_IDLE;
                        os_cnt_r <= {OSW{1'b0}};
                        busy_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (baud),
        .reset     (reset),
        .push      (push_s),
        .push_data (shift_r),
        .pop       (pop_s),
        .head      (rx_if.data_out),
        .count     (rx_if.fifo_count),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param with default parameters
// (8 data bits, even parity, 1 stop bit, 16x oversampling, 4-entry FIFO).
// Frames are built bit by bit on rx; expectations come from a queue model
// of the FIFO and the frame rules (parity, stop bit, overrun on full).
module tb_uart_rx_param;
    import uart_rx_pkg::*;

    localparam int OS = 16;

    logic baud   = 1'b0;
    logic reset  = 1'b1;
    logic enable = 1'b0;
    logic rx     = 1'b1;
    logic busy;
    logic parity_err;
    logic frame_err;
    logic overrun;

    int total = 0;
    int bad   = 0;
    int pe_seen = 0, fe_seen = 0, ov_seen = 0, busy_seen = 0;
    logic [7:0] exp_q[$];

    uart_rx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) rif ();

    uart_rx_param #(
        .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLING(OS), .FIFO_DEPTH(4)
    ) dut (
        .baud       (baud),
        .reset      (reset),
        .enable     (enable),
        .rx         (rx),
        .rx_if      (rif),
        .busy       (busy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 baud = ~baud;

    // Pulse / activity counters, sampled away from the active edge.
    always @(negedge baud) begin
        if (parity_err === 1'b1) pe_seen++;
        if (frame_err === 1'b1)  fe_seen++;
        if (overrun === 1'b1)    ov_seen++;
        if (busy === 1'b1)       busy_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic put_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge baud);
        #1;
    endtask

    // One frame; a bad stop bit is held low just past its sample point.
    task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop_ok);
        logic pbit;
        pbit = (^d) ^ ~par_ok;
        put_bit(1'b0, OS);
        for (int i = 0; i < 8; i++) put_bit(d[i], OS);
        put_bit(pbit, OS);
        if (stop_ok) put_bit(1'b1, OS);
        else         put_bit(1'b0, OS / 2 + 2);
        put_bit(1'b1, OS);
    endtask

    // Empty the DUT FIFO and the model queue.
    task automatic flush();
        int n;
        n = 0;
        rif.data_ready = 1'b1;
        while (rif.data_valid === 1'b1 && n < 8) begin
            @(posedge baud); #1;
            n++;
        end
        rif.data_ready = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge baud);
        @(negedge baud);
        total++; if (rif.data_out !== 8'h00)   begin bad++; $display("FAIL reset_data_out got=%0h want=0", rif.data_out); end
        total++; if (rif.data_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%0b want=0", rif.data_valid); end
        total++; if (rif.fifo_count !== 3'd0)  begin bad++; $display("FAIL reset_count got=%0d want=0", rif.fifo_count); end
        total++; if (busy !== 1'b0)            begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if ({parity_err, frame_err, overrun} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%03b want=000", {parity_err, frame_err, overrun}); end
        @(posedge baud); #1;
        reset  = 1'b0;
        enable = 1'b1;
        put_bit(1'b1, OS);
    endtask

    task automatic test_basic();
        int p0, f0, o0;
        p0 = pe_seen; f0 = fe_seen; o0 = ov_seen;
        send_frame(8'hA5, 1'b1, 1'b1);
        @(negedge baud);
        total++; if (rif.data_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b want=1", rif.data_valid); end
        total++; if (rif.data_out !== 8'hA5)  begin bad++; $display("FAIL basic_data got=%0h want=a5", rif.data_out); end
        total++; if (rif.fifo_count !== 3'd1) begin bad++; $display("FAIL basic_count got=%0d want=1", rif.fifo_count); end
        total++; if (busy !== 1'b0)           begin bad++; $display("FAIL basic_busy got=%0b want=0", busy); end
        total++; if ((pe_seen - p0) + (fe_seen - f0) + (ov_seen - o0) !== 0) begin bad++; $display("FAIL basic_flags got=%0d pulses want=0", (pe_seen - p0) + (fe_seen - f0) + (ov_seen - o0)); end
        flush();
    endtask

    task automatic test_parity();
        int p0, f0;
        p0 = pe_seen; f0 = fe_seen;
        send_frame(8'h3C, 1'b0, 1'b1);
        @(negedge baud);
        total++; if (pe_seen - p0 !== 1)      begin bad++; $display("FAIL parity_pulse got=%0d want=1", pe_seen - p0); end
        total++; if (fe_seen - f0 !== 0)      begin bad++; $display("FAIL parity_no_fe got=%0d want=0", fe_seen - f0); end
        total++; if (rif.fifo_count !== 3'd0) begin bad++; $display("FAIL parity_count got=%0d want=0", rif.fifo_count); end
        send_frame(8'h3C, 1'b1, 1'b1);
        @(negedge baud);
        total++; if (rif.data_out !== 8'h3C)  begin bad++; $display("FAIL parity_recover_data got=%0h want=3c", rif.data_out); end
        total++; if (pe_seen - p0 !== 1)      begin bad++; $display("FAIL parity_recover_pulse got=%0d want=1", pe_seen - p0); end
        flush();
    endtask

    task automatic test_framing();
        int p0, f0;
        p0 = pe_seen; f0 = fe_seen;
        send_frame(8'h55, 1'b1, 1'b0);
        @(negedge baud);
        total++; if (fe_seen - f0 !== 1)      begin bad++; $display("FAIL frame_pulse got=%0d want=1", fe_seen - f0); end
        total++; if (pe_seen - p0 !== 0)      begin bad++; $display("FAIL frame_no_pe got=%0d want=0", pe_seen - p0); end
        total++; if (rif.fifo_count !== 3'd0) begin bad++; $display("FAIL frame_count got=%0d want=0", rif.fifo_count); end
        send_frame(8'h81, 1'b1, 1'b1);
        @(negedge baud);
        total++; if (rif.data_out !== 8'h81)  begin bad++; $display("FAIL frame_recover_data got=%0h want=81", rif.data_out); end
        total++; if (rif.fifo_count !== 3'd1) begin bad++; $display("FAIL frame_recover_count got=%0d want=1", rif.fifo_count); end
        total++; if (fe_seen - f0 !== 1)      begin bad++; $display("FAIL frame_recover_pulse got=%0d want=1", fe_seen - f0); end
        flush();
    endtask

    task automatic test_glitch();
        int b0, p0, f0, o0;
        b0 = busy_seen; p0 = pe_seen; f0 = fe_seen; o0 = ov_seen;
        put_bit(1'b0, 5);
        put_bit(1'b1, 2 * OS);
        @(negedge baud);
        total++; if (busy_seen - b0 !== 5)    begin bad++; $display("FAIL glitch_busy_cycles got=%0d want=5", busy_seen - b0); end
        total++; if (busy !== 1'b0)           begin bad++; $display("FAIL glitch_busy got=%0b want=0", busy); end
        total++; if (rif.fifo_count !== 3'd0) begin bad++; $display("FAIL glitch_count got=%0d want=0", rif.fifo_count); end
        total++; if ((pe_seen - p0) + (fe_seen - f0) + (ov_seen - o0) !== 0) begin bad++; $display("FAIL glitch_flags got=%0d pulses want=0", (pe_seen - p0) + (fe_seen - f0) + (ov_seen - o0)); end
    endtask

    task automatic test_overrun();
        int o0;
        logic [7:0] want;
        o0 = ov_seen;
        rif.data_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1);
        @(negedge baud);
        total++; if (rif.fifo_count !== 3'd4) begin bad++; $display("FAIL overrun_count got=%0d want=4", rif.fifo_count); end
        total++; if (ov_seen - o0 !== 1)      begin bad++; $display("FAIL overrun_pulse got=%0d want=1", ov_seen - o0); end
        @(posedge baud); #1;
        for (int i = 1; i <= 4; i++) begin
            want = 8'(i);
            rif.data_ready = 1'b1;
            @(negedge baud);
            total++; if (rif.data_out !== want) begin bad++; $display("FAIL overrun_drain[%0d] got=%0h want=%0h", i, rif.data_out, want); end
            @(posedge baud); #1;
            rif.data_ready = 1'b0;
        end
        @(negedge baud);
        total++; if (rif.data_valid !== 1'b0) begin bad++; $display("FAIL overrun_empty got=%0b want=0", rif.data_valid); end
        @(posedge baud); #1;
    endtask

    task automatic test_enable_abort();
        int p0, f0;
        p0 = pe_seen; f0 = fe_seen;
        put_bit(1'b0, OS);
        put_bit(1'b0, OS);
        enable = 1'b0;
        put_bit(1'b1, 2);
        @(negedge baud);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL enable_busy got=%0b want=0", busy); end
        @(posedge baud); #1;
        put_bit(1'b1, OS);
        enable = 1'b1;
        put_bit(1'b1, OS);
        send_frame(8'h5A, 1'b1, 1'b1);
        @(negedge baud);
        total++; if (rif.data_out !== 8'h5A)  begin bad++; $display("FAIL enable_next_data got=%0h want=5a", rif.data_out); end
        total++; if (rif.fifo_count !== 3'd1) begin bad++; $display("FAIL enable_next_count got=%0d want=1", rif.fifo_count); end
        total++; if ((pe_seen - p0) + (fe_seen - f0) !== 0) begin bad++; $display("FAIL enable_flags got=%0d want=0", (pe_seen - p0) + (fe_seen - f0)); end
        flush();
    endtask

    task automatic test_reset_mid();
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        @(negedge baud);
        total++; if (rif.fifo_count !== 3'd2) begin bad++; $display("FAIL rmid_pre_count got=%0d want=2", rif.fifo_count); end
        @(posedge baud); #1;
        put_bit(1'b0, OS);
        put_bit(1'b1, OS);
        put_bit(1'b0, OS / 2);
        reset = 1'b1;
        @(posedge baud); #1;
        reset = 1'b0;
        rx    = 1'b1;
        @(negedge baud);
        total++; if (busy !== 1'b0)           begin bad++; $display("FAIL rmid_busy got=%0b want=0", busy); end
        total++; if (rif.data_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b want=0", rif.data_valid); end
        total++; if (rif.fifo_count !== 3'd0) begin bad++; $display("FAIL rmid_count got=%0d want=0", rif.fifo_count); end
        total++; if (rif.data_out !== 8'h00)  begin bad++; $display("FAIL rmid_data got=%0h want=0", rif.data_out); end
        @(posedge baud); #1;
        put_bit(1'b1, OS);
        send_frame(8'h7E, 1'b1, 1'b1);
        @(negedge baud);
        total++; if (rif.data_out !== 8'h7E)  begin bad++; $display("FAIL rmid_next_data got=%0h want=7e", rif.data_out); end
        total++; if (rif.fifo_count !== 3'd1) begin bad++; $display("FAIL rmid_next_count got=%0d want=1", rif.fifo_count); end
        flush();
    endtask

    task automatic test_random();
        int p0, f0, o0, ep, ef, eo, k;
        logic [7:0] d;
        logic par_ok, stop_ok;
        p0 = pe_seen; f0 = fe_seen; o0 = ov_seen;
        ep = 0; ef = 0; eo = 0;
        exp_q.delete();
        for (int f = 0; f < 14; f++) begin
            d       = 8'($urandom);
            par_ok  = ($urandom_range(0, 3) != 0);
            stop_ok = ($urandom_range(0, 4) != 0);
            send_frame(d, par_ok, stop_ok);
            if (!par_ok) ep++;
            if (!stop_ok) ef++;
            if (par_ok && stop_ok) begin
                if (exp_q.size() < 4) exp_q.push_back(d);
                else eo++;
            end
            k = $urandom_range(0, exp_q.size());
            for (int j = 0; j < k; j++) begin
                rif.data_ready = 1'b1;
                @(negedge baud);
                total++; if (rif.data_out !== exp_q[0]) begin bad++; $display("FAIL rand_pop[%0d] got=%0h want=%0h", f, rif.data_out, exp_q[0]); end
                @(posedge baud); #1;
                rif.data_ready = 1'b0;
                void'(exp_q.pop_front());
            end
        end
        @(negedge baud);
        total++; if (rif.fifo_count !== 3'(exp_q.size())) begin bad++; $display("FAIL rand_count got=%0d want=%0d", rif.fifo_count, exp_q.size()); end
        total++; if (pe_seen - p0 !== ep) begin bad++; $display("FAIL rand_parity_pulses got=%0d want=%0d", pe_seen - p0, ep); end
        total++; if (fe_seen - f0 !== ef) begin bad++; $display("FAIL rand_frame_pulses got=%0d want=%0d", fe_seen - f0, ef); end
        total++; if (ov_seen - o0 !== eo) begin bad++; $display("FAIL rand_overrun_pulses got=%0d want=%0d", ov_seen - o0, eo); end
        @(posedge baud); #1;
        while (exp_q.size() > 0) begin
            rif.data_ready = 1'b1;
            @(negedge baud);
            total++; if (rif.data_out !== exp_q[0]) begin bad++; $display("FAIL rand_drain got=%0h want=%0h", rif.data_out, exp_q[0]); end
            @(posedge baud); #1;
            rif.data_ready = 1'b0;
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        rif.data_ready = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_glitch();
        test_overrun();
        test_enable_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
